// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: default geometry, FSM
// state encoding and the address-field width helpers.
package icache_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_LINES      = 16;
    localparam int DEF_CNT_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Tag width left over once the byte offset, word offset and index are removed.
    function automatic int tag_bits(input int data_width, input int off_bits, input int idx_bits);
        return data_width - 2 - off_bits - idx_bits;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-port, memory-read-bus, flush and perf-counter signals of the icache.
//
// Handshakes:
//  fetch : the core raises inst_req with inst_addr and holds both until the
//          one-cycle inst_valid pulse; inst_data is meaningful in that cycle
//          and holds its value afterwards.
//  memory: the cache raises mem_req with a word-aligned mem_addr and holds
//          both until memory answers with a one-cycle mem_valid/mem_rdata;
//          during a refill mem_req stays high across consecutive beats while
//          mem_addr advances by one word per accepted beat.
interface icache_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  inst_req;
    logic [DATA_WIDTH-1:0] inst_addr;
    logic                  inst_valid;
    logic [DATA_WIDTH-1:0] inst_data;
    logic                  mem_req;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  flush;
    logic [CNT_WIDTH-1:0]  hit_count;
    logic [CNT_WIDTH-1:0]  miss_count;

    // Cache side.
    modport slave (
        input  inst_req, inst_addr, mem_valid, mem_rdata, flush,
        output inst_valid, inst_data, mem_req, mem_addr, hit_count, miss_count
    );

    // Core / memory / environment side.
    modport master (
        output inst_req, inst_addr, mem_valid, mem_rdata, flush,
        input  inst_valid, inst_data, mem_req, mem_addr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_data_array.sv
// Line data storage: LINES x LINE_WORDS words, one synchronous write port
// addressed by (line, beat) and one combinational read port by (line, word).
module icache_data_array
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LINES      = DEF_LINES
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(LINES)-1:0]      widx,
    input  logic [$clog2(LINE_WORDS)-1:0] wbeat,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [$clog2(LINES)-1:0]      ridx,
    input  logic [$clog2(LINE_WORDS)-1:0] rword,
    output logic [DATA_WIDTH-1:0]         rdata
);
    logic [DATA_WIDTH-1:0] mem [LINES*LINE_WORDS];

    // Refill beat write; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[{widx, wbeat}] <= wdata;
    end

    assign rdata = mem[{ridx, rword}];
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. Hits answer one cycle after
// acceptance; misses refill the whole line word by word, forward the
// requested word and then answer.
module icache
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LINES      = DEF_LINES,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic   clk,
    input  logic   rst,
    icache_if.slave bus,
    output state_t state_dbg
);
    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = tag_bits(DATA_WIDTH, OFF_BITS, IDX_BITS);
    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

    state_t state, state_nxt;

    logic [OFF_BITS-1:0]   req_word, lat_word, beat;
    logic [IDX_BITS-1:0]   req_idx, lat_idx;
    logic [TAG_BITS-1:0]   req_tag, lat_tag;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q [LINES];
    logic                  flush_seen;
    logic                  hit, accept_hit, accept_miss, last_beat;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_addr_bits;

    assign req_word = bus.inst_addr[OFF_BITS+1:2];
    assign req_idx  = bus.inst_addr[IDX_BITS+OFF_BITS+1:OFF_BITS+2];
    assign req_tag  = bus.inst_addr[DATA_WIDTH-1:IDX_BITS+OFF_BITS+2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_addr_bits = ^bus.inst_addr[1:0];

    assign bus.inst_valid = (state == RESPOND);
    assign state_dbg      = state;

    icache_data_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .LINE_WORDS(LINE_WORDS),
        .LINES     (LINES)
    ) u_data (
        .clk  (clk),
        .we   (state == REFILL && bus.mem_valid),
        .widx (lat_idx),
        .wbeat(beat),
        .wdata(bus.mem_rdata),
        .ridx (req_idx),
        .rword(req_word),
        .rdata(rd_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and the accept / last-beat strobes that drive the datapath.
    always_comb begin
        state_nxt   = state;
        accept_hit  = 1'b0;
        accept_miss = 1'b0;
        last_beat   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.inst_req) begin
                    if (hit) begin
                        accept_hit = 1'b1;
                        state_nxt  = RESPOND;
                    end else begin
                        accept_miss = 1'b1;
                        state_nxt   = REFILL;
                    end
                end
            end
            REFILL: begin
                if (bus.mem_valid && beat == LAST_BEAT) begin
                    last_beat = 1'b1;
                    state_nxt = RESPOND;
                end
            end
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latching, memory bus sequencing and returned-word capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.inst_data <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            lat_word      <= '0;
            lat_idx       <= '0;
            lat_tag       <= '0;
            beat          <= '0;
            flush_seen    <= 1'b0;
        end else begin
            if (accept_hit) bus.inst_data <= rd_data;
            if (accept_miss) begin
                lat_word     <= req_word;
                lat_idx      <= req_idx;
                lat_tag      <= req_tag;
                beat         <= '0;
                flush_seen   <= 1'b0;
                bus.mem_req  <= 1'b1;
                bus.mem_addr <= {bus.inst_addr[DATA_WIDTH-1:OFF_BITS+2], {(OFF_BITS+2){1'b0}}};
            end
            if (state == REFILL && bus.mem_valid) begin
                // The requested word is forwarded straight from the bus.
                if (beat == lat_word) bus.inst_data <= bus.mem_rdata;
                if (last_beat) begin
                    bus.mem_req <= 1'b0;
                end else begin
                    beat         <= beat + 1'b1;
                    bus.mem_addr <= bus.mem_addr + DATA_WIDTH'(4);
                end
            end
            if (state == REFILL && bus.flush) flush_seen <= 1'b1;
        end
    end

    // Valid bits: flush wins; a refill disturbed by a flush leaves its line invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
        end else if (last_beat && !flush_seen) begin
            valid_q[lat_idx] <= 1'b1;
        end
    end

    // Tag written when the line's last beat arrives; tags are not reset.
    always_ff @(posedge clk) begin
        if (last_beat) tag_q[lat_idx] <= lat_tag;
    end

    // Hit / miss performance counters, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.hit_count  <= '0;
            bus.miss_count <= '0;
        end else begin
            if (accept_hit)  bus.hit_count  <= bus.hit_count + CNT_WIDTH'(1);
            if (accept_miss) bus.miss_count <= bus.miss_count + CNT_WIDTH'(1);
        end
    end
endmodule
